lsu_seq: RTL and testbench
==========================

# lsu_seq

Load/store sequencer that sits between the MEM pipeline stage and `datamem`. It is the initiator on the `datamem` port (WE/WidthSrc/A/WD/RD). It accepts one RISC-V load or store request per handshake and issues the required memory accesses. Misaligned halfword and word accesses are split into byte accesses. Load results are reassembled and sign- or zero-extended before being returned to the pipeline.

## Interface
- No parameters; all addresses and data are 32 bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ReqValid` in 1: request present.
- `ReqReady` out 1: sequencer can accept; high only in IDLE while `reset`=0.
- `ReqWrite` in 1: 1 = store, 0 = load.
- `ReqFunct3` in 3: RISC-V funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW).
- `ReqAddr` in 32: byte address.
- `ReqData` in 32: store data; the low bytes are used for SB/SH.
- `RespValid` out 1: one-cycle completion pulse; no backpressure.
- `RespData` out 32: extended load result; 0 for stores and errors.
- `RespErr` out 1: illegal funct3; valid with `RespValid`.
- `RespMisaligned` out 1: request was split; valid with `RespValid`.
- `MemWE` out 1: `datamem` write enable.
- `MemWidthSrc` out 2: 00 word, 10 halfword, 01 byte.
- `MemA` out 32: byte address to `datamem`.
- `MemWD` out 32: write data. The byte or halfword is placed in its low bits.
- `MemRD` in 32: combinational read data from `datamem`. The addressed byte or halfword is in its low bits.

## Operation
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE: `ReqReady`=1. When `ReqValid`=1 at an edge, the sequencer latches write, funct3, addr and data.
  - Illegal funct3 goes to RESP with `RespErr`=1 and no memory access.
  - An aligned request goes to ACCESS. Alignment rule: byte is always aligned; half requires addr[0]=0; word requires addr[1:0]=0.
  - A misaligned request goes to SPLIT with byte counter k=0.
- ACCESS: drives `MemA`=addr, `MemWidthSrc` per size and `MemWD`=data, for one cycle.
  - `MemWE`=1 only for stores.
  - For loads, `MemRD` is captured at the edge ending the cycle.
  - Next state is RESP.
- SPLIT: in each cycle the sequencer drives `MemWidthSrc`=01 and `MemA`=addr+k (mod 2^32).
  - Stores: `MemWE`=1 and `MemWD`[7:0]=data byte k.
  - Loads: `MemRD`[7:0] is captured into assembly byte k, little-endian.
  - k increments each cycle. The state exits to RESP after k=1 for halfword or k=3 for word.
- RESP: `RespValid`=1 for one cycle, then IDLE. `RespMisaligned` reflects the SPLIT path.
- Load extension:
  - LB: sign from bit 7.
  - LH: sign from bit 15.
  - LBU/LHU: zero-extend.
  - LW: raw 32 bits.
- Outside ACCESS/SPLIT: `MemWE`=0, `MemA`=0, `MemWD`=0, `MemWidthSrc`=00.
- `RespData`, `RespErr` and `RespMisaligned` are 0 whenever `RespValid`=0.

## Timing
- Reset values:
  - State IDLE.
  - Outputs 0: `ReqReady`, `RespValid`, `RespData`, `RespErr`, `RespMisaligned`, `MemWE`, `MemA`, `MemWD` and `MemWidthSrc`.
  - `ReqReady` rises in the first cycle after `reset` deasserts.
- Latency, counted from the accept edge (edge 0), as the edge on which `RespValid` is high:
  - Aligned access: cycle 1 is the access, `RespValid` in cycle 2.
  - Misaligned halfword: `RespValid` in cycle 3.
  - Misaligned word: `RespValid` in cycle 5.
  - Illegal funct3: `RespValid` in cycle 1.
- `MemWE` is high for exactly one cycle per byte or aligned access. A store never asserts `MemWE` in IDLE or RESP.
- Throughput: no new request is accepted until the cycle after RESP. With `ReqValid` held high, aligned requests complete one per 3 cycles.
- Address wrap: a misaligned access at 0xFFFFFFFD wraps to 0x00000000 mid-sequence.
- Reset mid-operation:
  - The next state is IDLE and `MemWE` is 0 from that edge.
  - No `RespValid` is produced.
  - Bytes of a split store already written are not rolled back.
- `ReqValid` dropping while `ReqReady`=0 is ignored. Latched values hold until RESP.

## Test plan
- Reset, then SW 0xDEADBEEF @0x10, then LW @0x10:
  - SW: `MemWE` high for 1 cycle with `MemWidthSrc`=00.
  - LW: `RespData`=0xDEADBEEF, `RespValid` 2 cycles after accept, `RespMisaligned`=0.
- SB 0x80 @0x21, then LB @0x21 then LBU @0x21:
  - LB returns 0xFFFFFF80.
  - LBU returns 0x00000080.
  - `MemWidthSrc`=01 on all three.
- SW 0x11223344 @0x03:
  - Four consecutive byte writes, `MemA` 0x03..0x06, `MemWD`[7:0] = 44, 33, 22, 11.
  - Then LW @0x03 returns 0x11223344 with `RespMisaligned`=1, `RespValid` 5 cycles after accept.
  - Then LH @0x05 returns 0x00001122.
- Load with funct3=011:
  - `RespValid` 1 cycle after accept with `RespErr`=1 and `RespData`=0.
  - `MemWE` and `MemA` remain 0.
- Reset asserted during SPLIT k=2 of SW 0xAABBCCDD @0x41:
  - `MemWE`=0 from the next edge and no `RespValid`.
  - `ReqReady`=1 after release.
  - A subsequent byte read of 0x41 returns 0xDD and 0x42 returns 0xCC; 0x43 and 0x44 are unchanged.
- `ReqValid` held high with LW @0x10 followed by SW @0x14:
  - The second request is accepted on the cycle after the first `RespValid`.
  - `ReqReady`=0 in ACCESS and RESP.

Source files
------------

// File: rtl/lsu_seq.sv
// rtl/lsu_seq.sv - load/store sequencer between MEM stage and datamem
// Misaligned halfword/word requests are split into little-endian byte accesses.
module lsu_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        ReqWrite,
   input  logic [2:0]  ReqFunct3,
   input  logic [31:0] ReqAddr,
   input  logic [31:0] ReqData,
   output logic        RespValid,
   output logic [31:0] RespData,
   output logic        RespErr,
   output logic        RespMisaligned,
   output logic        MemWE,
   output logic [1:0]  MemWidthSrc,
   output logic [31:0] MemA,
   output logic [31:0] MemWD,
   input  logic [31:0] MemRD
);
   typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

   state_t      state, state_next;
   logic        write_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic [31:0] load_q;
   logic [1:0]  k_q;
   logic        err_q;
   logic        mis_q;
   logic        req_legal;
   logic        req_misaligned;
   logic        split_last;
   logic [31:0] load_ext;

   always_comb begin
      if (ReqWrite) begin
         req_legal = (ReqFunct3[2] == 1'b0) && (ReqFunct3[1:0] != 2'b11);
      end else begin
         req_legal = (ReqFunct3 != 3'b011) && (ReqFunct3 != 3'b110) && (ReqFunct3 != 3'b111);
      end
      case (ReqFunct3[1:0])
         2'b01:   req_misaligned = ReqAddr[0];
         2'b10:   req_misaligned = (ReqAddr[1:0] != 2'b00);
         default: req_misaligned = 1'b0;
      endcase
   end

   assign split_last = (funct3_q[1:0] == 2'b01) ? (k_q == 2'd1) : (k_q == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         write_q  <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         data_q   <= 32'h0;
         load_q   <= 32'h0;
         k_q      <= 2'd0;
         err_q    <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (ReqValid) begin
                  write_q  <= ReqWrite;
                  funct3_q <= ReqFunct3;
                  addr_q   <= ReqAddr;
                  data_q   <= ReqData;
                  load_q   <= 32'h0;
                  k_q      <= 2'd0;
                  err_q    <= !req_legal;
                  mis_q    <= req_legal && req_misaligned;
               end
            end
            ACCESS: begin
               if (!write_q) load_q <= MemRD;
            end
            SPLIT: begin
               if (!write_q) load_q[{k_q, 3'b000} +: 8] <= MemRD[7:0];
               k_q <= k_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (ReqValid) begin
               if (!req_legal)          state_next = RESP;
               else if (req_misaligned) state_next = SPLIT;
               else                     state_next = ACCESS;
            end
         end
         ACCESS:  state_next = RESP;
         SPLIT:   state_next = split_last ? RESP : SPLIT;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      case (funct3_q)
         3'b000:  load_ext = {{24{load_q[7]}}, load_q[7:0]};
         3'b001:  load_ext = {{16{load_q[15]}}, load_q[15:0]};
         3'b010:  load_ext = load_q;
         3'b100:  load_ext = {24'h0, load_q[7:0]};
         3'b101:  load_ext = {16'h0, load_q[15:0]};
         default: load_ext = 32'h0;
      endcase
   end

   // All outputs are forced low while reset is held, so an interrupted split store stops immediately.
   always_comb begin
      ReqReady       = 1'b0;
      RespValid      = 1'b0;
      RespData       = 32'h0;
      RespErr        = 1'b0;
      RespMisaligned = 1'b0;
      MemWE          = 1'b0;
      MemWidthSrc    = 2'b00;
      MemA           = 32'h0;
      MemWD          = 32'h0;
      if (!reset) begin
         case (state)
            IDLE: ReqReady = 1'b1;
            ACCESS: begin
               MemWE = write_q;
               MemA  = addr_q;
               MemWD = data_q;
               case (funct3_q[1:0])
                  2'b00:   MemWidthSrc = 2'b01;
                  2'b01:   MemWidthSrc = 2'b10;
                  default: MemWidthSrc = 2'b00;
               endcase
            end
            SPLIT: begin
               MemWE       = write_q;
               MemWidthSrc = 2'b01;
               MemA        = addr_q + {30'h0, k_q};
               MemWD       = {24'h0, data_q[{k_q, 3'b000} +: 8]};
            end
            RESP: begin
               RespValid      = 1'b1;
               RespErr        = err_q;
               RespMisaligned = mis_q;
               RespData       = (err_q || write_q) ? 32'h0 : load_ext;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_seq.sv
// tb/tb_lsu_seq.sv - scoreboard bench for lsu_seq with a byte-array datamem
// Expected responses and memory accesses are queued at issue time and popped by a monitor.
module tb_lsu_seq;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ReqValid = 1'b0;
   logic        ReqWrite = 1'b0;
   logic [2:0]  ReqFunct3 = 3'b000;
   logic [31:0] ReqAddr = 32'h0;
   logic [31:0] ReqData = 32'h0;
   logic        ReqReady, RespValid, RespErr, RespMisaligned, MemWE;
   logic [31:0] RespData, MemA, MemWD, MemRD;
   logic [1:0]  MemWidthSrc;

   lsu_seq dut (
      .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqWrite(ReqWrite), .ReqFunct3(ReqFunct3), .ReqAddr(ReqAddr), .ReqData(ReqData),
      .RespValid(RespValid), .RespData(RespData), .RespErr(RespErr),
      .RespMisaligned(RespMisaligned), .MemWE(MemWE), .MemWidthSrc(MemWidthSrc),
      .MemA(MemA), .MemWD(MemWD), .MemRD(MemRD)
   );

   always #5 clk = ~clk;

   // datamem stand-in: 256 bytes, address aliased on the low 8 bits
   logic [7:0] mem [256];
   logic [7:0] rmem [256];
   logic [7:0] a0, a1, a2, a3;

   always_comb begin
      a0 = MemA[7:0];
      a1 = a0 + 8'd1;
      a2 = a0 + 8'd2;
      a3 = a0 + 8'd3;
      case (MemWidthSrc)
         2'b00:   MemRD = {mem[a3], mem[a2], mem[a1], mem[a0]};
         2'b10:   MemRD = {16'h0, mem[a1], mem[a0]};
         2'b01:   MemRD = {24'h0, mem[a0]};
         default: MemRD = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      if (MemWE) begin
         mem[a0] <= MemWD[7:0];
         if (MemWidthSrc != 2'b01) mem[a1] <= MemWD[15:8];
         if (MemWidthSrc == 2'b00) begin
            mem[a2] <= MemWD[23:16];
            mem[a3] <= MemWD[31:24];
         end
      end
   end

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        mis;
      int          acc;
      int          lat;
   } resp_t;

   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [1:0]  w;
      logic [31:0] wd;
   } acc_t;

   resp_t rq[$];
   acc_t  aq[$];
   int    cyc = 0;
   int    checks = 0;
   int    fails = 0;
   int    last_resp_edge = -10;
   resp_t me;
   acc_t  ma;
   logic [31:0] mask;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (RespValid) begin
            check("resp_ready_low", {31'h0, ReqReady}, 32'h0);
            check("resp_mem_idle", {28'h0, MemWE, MemWidthSrc, |MemA}, 32'h0);
            check("resp_queued", {31'h0, rq.size() != 0}, 32'h1);
            if (rq.size() != 0) begin
               me = rq.pop_front();
               check("resp_data", RespData, me.data);
               check("resp_err", {31'h0, RespErr}, {31'h0, me.err});
               check("resp_mis", {31'h0, RespMisaligned}, {31'h0, me.mis});
               check("resp_latency", 32'(cyc + 1 - me.acc), 32'(me.lat));
            end
            last_resp_edge = cyc + 1;
         end else if (!ReqReady) begin
            check("access_idle_resp", RespData | {30'h0, RespErr, RespMisaligned}, 32'h0);
            check("access_queued", {31'h0, aq.size() != 0}, 32'h1);
            if (aq.size() != 0) begin
               ma = aq.pop_front();
               check("mem_we", {31'h0, MemWE}, {31'h0, ma.we});
               check("mem_addr", MemA, ma.a);
               check("mem_width", {30'h0, MemWidthSrc}, {30'h0, ma.w});
               if (ma.we) begin
                  mask = (ma.w == 2'b01) ? 32'hFF : (ma.w == 2'b10) ? 32'hFFFF : 32'hFFFF_FFFF;
                  check("mem_wd", MemWD & mask, ma.wd & mask);
               end
            end
         end
      end
   end

   task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input bit drop, output int acc);
      int          n, sz;
      bit          legal, mis;
      logic [31:0] v;
      resp_t       e;
      acc_t        x;
      @(negedge clk);
      ReqValid = 1'b1; ReqWrite = w; ReqFunct3 = f3; ReqAddr = a; ReqData = d;
      n = 0;
      while (!ReqReady && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ReqReady) check("accept_timeout", {31'h0, ReqReady}, 32'h1);
      legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mis   = legal && ((a % sz) != 0);
      acc   = cyc + 1;
      e.acc = acc;
      e.err = !legal;
      e.mis = mis;
      e.lat = !legal ? 1 : (mis ? sz + 1 : 2);
      e.data = 32'h0;
      if (legal) begin
         if (w) begin
            for (int i = 0; i < sz; i++) rmem[8'(a + 32'(i))] = 8'(d >> (8 * i));
         end else begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v = v | (32'(rmem[8'(a + 32'(i))]) << (8 * i));
            if (f3 == 3'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
            if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            e.data = v;
         end
         if (mis) begin
            for (int i = 0; i < sz; i++) begin
               x.we = w; x.a = a + 32'(i); x.w = 2'b01; x.wd = d >> (8 * i);
               aq.push_back(x);
            end
         end else begin
            x.we = w; x.a = a; x.wd = d;
            x.w  = (sz == 1) ? 2'b01 : (sz == 2) ? 2'b10 : 2'b00;
            aq.push_back(x);
         end
      end
      rq.push_back(e);
      @(posedge clk);
      #1;
      if (drop) ReqValid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (rq.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain", rq.size(), 32'h0);
      @(negedge clk);
   endtask

   int          acc1, acc2;
   logic [7:0]  old43, old44;
   logic [2:0]  rf3;
   logic [31:0] raddr;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]  = 8'(i) ^ 8'h5A;
         rmem[i] = 8'(i) ^ 8'h5A;
      end
      repeat (3) @(negedge clk);
      check("reset_ctrl", {25'h0, ReqReady, RespValid, RespErr, RespMisaligned, MemWE, MemWidthSrc}, 32'h0);
      check("reset_data", RespData | MemA | MemWD, 32'h0);
      reset = 1'b0;
      #1;
      check("ready_after_reset", {31'h0, ReqReady}, 32'h1);

      issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1, acc1);
      issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, acc1);
      issue(1'b1, 3'd0, 32'h21, 32'h80, 1'b1, acc1);
      issue(1'b0, 3'd0, 32'h21, 32'h0, 1'b1, acc1);
      issue(1'b0, 3'd4, 32'h21, 32'h0, 1'b1, acc1);
      issue(1'b1, 3'd2, 32'h03, 32'h11223344, 1'b1, acc1);
      issue(1'b0, 3'd2, 32'h03, 32'h0, 1'b1, acc1);
      issue(1'b0, 3'd1, 32'h05, 32'h0, 1'b1, acc1);
      issue(1'b0, 3'd3, 32'h08, 32'h0, 1'b1, acc1);
      issue(1'b1, 3'd2, 32'hFFFF_FFFD, 32'hCAFEF00D, 1'b1, acc1);
      issue(1'b0, 3'd2, 32'hFFFF_FFFD, 32'h0, 1'b1, acc1);
      issue(1'b0, 3'd5, 32'hFFFF_FFFF, 32'h0, 1'b1, acc1);
      drain();

      // reset lands in the k=2 cycle of a split word store
      old43 = rmem[8'h43];
      old44 = rmem[8'h44];
      issue(1'b1, 3'd2, 32'h41, 32'hAABBCCDD, 1'b1, acc1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("reset_mid_we", {30'h0, MemWE, RespValid}, 32'h0);
      @(negedge clk);
      rq.delete();
      aq.delete();
      rmem[8'h43] = old43;
      rmem[8'h44] = old44;
      reset = 1'b0;
      #1;
      check("ready_after_mid_reset", {31'h0, ReqReady}, 32'h1);
      repeat (3) @(negedge clk);
      issue(1'b0, 3'd4, 32'h41, 32'h0, 1'b1, acc1);
      issue(1'b0, 3'd4, 32'h42, 32'h0, 1'b1, acc1);
      issue(1'b0, 3'd4, 32'h43, 32'h0, 1'b1, acc1);
      issue(1'b0, 3'd4, 32'h44, 32'h0, 1'b1, acc1);
      drain();

      issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, acc1);
      issue(1'b1, 3'd2, 32'h14, 32'h12345678, 1'b1, acc2);
      check("back_to_back_accept", 32'(acc2), 32'(last_resp_edge + 1));
      check("throughput_3cyc", 32'(acc2 - acc1), 32'd3);
      drain();

      for (int t = 0; t < 120; t++) begin
         rf3   = 3'($urandom_range(0, 7));
         raddr = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)))
                                             : 32'($urandom_range(0, 255));
         issue(1'($urandom_range(0, 1)), rf3, raddr, $urandom, 1'($urandom_range(0, 1)), acc1);
      end
      drain();
      check("access_queue_empty", aq.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
